// File: rtl/trg_one_gen_if.sv
// rtl/trg_one_gen_if.sv - trigger source / pulse bundle for trg_one_gen.
// TRG_CNT exists only when TRG_ONE_GEN_CNT_EN is defined.
interface trg_one_gen_if;
  logic       IN;
  logic       TRG_ONE;
  logic       LEVEL;
`ifdef TRG_ONE_GEN_CNT_EN
  logic [7:0] TRG_CNT;

  modport master (output IN, input TRG_ONE, input LEVEL, input TRG_CNT);
  modport slave  (input IN, output TRG_ONE, output LEVEL, output TRG_CNT);
`else
  modport master (output IN, input TRG_ONE, input LEVEL);
  modport slave  (input IN, output TRG_ONE, output LEVEL);
`endif
endinterface

// File: rtl/trg_one_gen.sv
// rtl/trg_one_gen.sv - synchronised, debounced single-pulse trigger generator.
// Optional pulse counter TRG_CNT enabled by macro TRG_ONE_GEN_CNT_EN.
module trg_one_gen #(
  parameter logic [7:0] DB_N = 8'h04,
  parameter logic [0:0] EDGE = 1'b0
) (
  input  logic         CLK,
  input  logic         R,
  trg_one_gen_if.slave bus
);

  localparam logic [1:0] S_LOW      = 2'd0;
  localparam logic [1:0] S_RISE_CHK = 2'd1;
  localparam logic [1:0] S_HIGH     = 2'd2;
  localparam logic [1:0] S_FALL_CHK = 2'd3;

  // A zero setting behaves as one so the terminal count never underflows.
  localparam logic [7:0] DB_LAST = (DB_N == 8'd0) ? 8'd0 : (DB_N - 8'd1);

  logic       s1;
  logic       s2;
  logic [1:0] state;
  logic [7:0] cnt;
  logic       level_q;
  logic       trg_q;
  logic       accept_rise;
  logic       accept_fall;
  logic       fire;

  always_comb begin
    accept_rise = (state == S_RISE_CHK) && s2 && (cnt == DB_LAST);
    accept_fall = (state == S_FALL_CHK) && !s2 && (cnt == DB_LAST);
    fire        = EDGE ? accept_fall : accept_rise;
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      state   <= S_LOW;
      cnt     <= 8'd0;
      level_q <= 1'b0;
      trg_q   <= 1'b0;
    end else begin
      s1    <= bus.IN;
      s2    <= s1;
      trg_q <= fire;
      case (state)
        S_LOW: begin
          if (s2) begin
            state <= S_RISE_CHK;
            cnt   <= 8'd0;
          end
        end
        S_RISE_CHK: begin
          if (!s2) begin
            state <= S_LOW;
          end else if (cnt == DB_LAST) begin
            state   <= S_HIGH;
            level_q <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_HIGH: begin
          if (!s2) begin
            state <= S_FALL_CHK;
            cnt   <= 8'd0;
          end
        end
        S_FALL_CHK: begin
          if (s2) begin
            state <= S_HIGH;
          end else if (cnt == DB_LAST) begin
            state   <= S_LOW;
            level_q <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_LOW;
      endcase
    end
  end

  assign bus.TRG_ONE = trg_q;
  assign bus.LEVEL   = level_q;

`ifdef TRG_ONE_GEN_CNT_EN
  logic [7:0] trg_cnt_q;

  always_ff @(posedge CLK) begin
    if (R) begin
      trg_cnt_q <= 8'd0;
    end else if (fire && (trg_cnt_q != 8'hFF)) begin
      trg_cnt_q <= trg_cnt_q + 8'd1;
    end
  end

  assign bus.TRG_CNT = trg_cnt_q;
`endif

endmodule

// File: tb/tb_trg_one_gen.sv
// tb/tb_trg_one_gen.sv - directed bench for trg_one_gen (rising, falling and DB_N=0 instances).
// TRG_CNT checks are compiled in when TRG_ONE_GEN_CNT_EN is defined.
module tb_trg_one_gen;

  logic CLK;
  logic R;
  logic in_drv;
  int   n_pass;
  int   n_total;
  int   pulses_a;
  int   base_a;

  trg_one_gen_if if_a ();
  trg_one_gen_if if_f ();
  trg_one_gen_if if_z ();

  assign if_a.IN = in_drv;
  assign if_f.IN = in_drv;
  assign if_z.IN = in_drv;

  trg_one_gen #(.DB_N(8'h04), .EDGE(1'b0)) dut_a (.CLK(CLK), .R(R), .bus(if_a.slave));
  trg_one_gen #(.DB_N(8'h04), .EDGE(1'b1)) dut_f (.CLK(CLK), .R(R), .bus(if_f.slave));
  trg_one_gen #(.DB_N(8'h00), .EDGE(1'b0)) dut_z (.CLK(CLK), .R(R), .bus(if_z.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (if_a.TRG_ONE === 1'b1) pulses_a++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    pulses_a = 0;
    R        = 1'b1;
    in_drv   = 1'b1;
    tick(3);
    check("rst_trg_a", {31'd0, if_a.TRG_ONE}, 32'd0);
    check("rst_lvl_a", {31'd0, if_a.LEVEL}, 32'd0);
    check("rst_trg_f", {31'd0, if_f.TRG_ONE}, 32'd0);
    check("rst_lvl_z", {31'd0, if_z.LEVEL}, 32'd0);
    in_drv = 1'b0;
    R      = 1'b0;
    tick(4);

    // Rising edge held: DB_N=4 pulses after edge 7, DB_N=0 after edge 4.
    in_drv = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("rise_trg_a_e%0d", k), {31'd0, if_a.TRG_ONE}, {31'd0, k == 7});
      check($sformatf("rise_lvl_a_e%0d", k), {31'd0, if_a.LEVEL}, {31'd0, k >= 7});
      check($sformatf("rise_trg_f_e%0d", k), {31'd0, if_f.TRG_ONE}, 32'd0);
      check($sformatf("rise_lvl_f_e%0d", k), {31'd0, if_f.LEVEL}, {31'd0, k >= 7});
      check($sformatf("rise_trg_z_e%0d", k), {31'd0, if_z.TRG_ONE}, {31'd0, k == 4});
    end
`ifdef TRG_ONE_GEN_CNT_EN
    check("cnt_after_one", {24'd0, if_a.TRG_CNT}, 32'd1);
`endif
    tick(12);

    // Falling edge: only the EDGE=1 instance pulses, after the full debounce.
    in_drv = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("fall_trg_f_e%0d", k), {31'd0, if_f.TRG_ONE}, {31'd0, k == 7});
      check($sformatf("fall_trg_a_e%0d", k), {31'd0, if_a.TRG_ONE}, 32'd0);
      check($sformatf("fall_lvl_a_e%0d", k), {31'd0, if_a.LEVEL}, {31'd0, k < 7});
      check($sformatf("fall_trg_z_e%0d", k), {31'd0, if_z.TRG_ONE}, 32'd0);
    end
    tick(4);

    // Short glitch of three cycles is rejected by the DB_N=4 instances.
    in_drv = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) in_drv = 1'b0;
      tick(1);
      check($sformatf("glitch_trg_a_e%0d", k), {31'd0, if_a.TRG_ONE}, 32'd0);
      check($sformatf("glitch_lvl_a_e%0d", k), {31'd0, if_a.LEVEL}, 32'd0);
      check($sformatf("glitch_trg_f_e%0d", k), {31'd0, if_f.TRG_ONE}, 32'd0);
    end
    tick(8);

    // Reset while in RISE_CHK with cnt=2, then a full debounce after release.
    in_drv = 1'b1;
    tick(5);
    R = 1'b1;
    tick(1);
    R = 1'b0;
    check("midrst_trg_a", {31'd0, if_a.TRG_ONE}, 32'd0);
    check("midrst_lvl_a", {31'd0, if_a.LEVEL}, 32'd0);
    check("midrst_lvl_z", {31'd0, if_z.LEVEL}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("rel_trg_a_e%0d", k), {31'd0, if_a.TRG_ONE}, {31'd0, k == 7});
      check($sformatf("rel_trg_z_e%0d", k), {31'd0, if_z.TRG_ONE}, {31'd0, k == 4});
    end
    in_drv = 1'b0;
    tick(12);

    // 300 clean pulses; TRG_CNT saturates and clears on reset.
    base_a = pulses_a;
    for (int p = 0; p < 300; p++) begin
      in_drv = 1'b1;
      tick(8);
      in_drv = 1'b0;
      tick(8);
    end
    tick(2);
    check("pulse_count_300", pulses_a - base_a, 32'd300);
`ifdef TRG_ONE_GEN_CNT_EN
    check("cnt_saturated", {24'd0, if_a.TRG_CNT}, 32'hFF);
    R = 1'b1;
    tick(1);
    R = 1'b0;
    check("cnt_after_rst", {24'd0, if_a.TRG_CNT}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
